// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge pulse generator: edge-mode
// encodings, the per-channel FSM state type and the parameter legality rule.
package edge_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  // Evaluated at elaboration by the top; any out-of-range parameter stops the build.
  function automatic bit params_legal(int channels, int sync_stages, int filter_len,
                                      int edge_mode, int pulse_len, int retrigger);
    return (channels    >= 1) && (channels    <= 32)  &&
           (sync_stages >= 2) && (sync_stages <= 4)   &&
           (filter_len  >= 0) && (filter_len  <= 255) &&
           (edge_mode   >= EDGE_RISE) && (edge_mode <= EDGE_BOTH) &&
           (pulse_len   >= 1) && (pulse_len   <= 255) &&
           (retrigger   >= 0) && (retrigger   <= 1);
  endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// One channel: synchroniser chain, stability filter, edge detector and the
// IDLE/PULSE stretcher. Next-state pulse is exported so the top can register o_Any.
module edge_pulse_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int PULSE_LEN   = 1,
  parameter int RETRIGGER   = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic pulse_o,
  output logic pulse_d_o,
  output logic level_o,
  output logic miss_o
);

  localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;
  logic                   level;
  logic                   prev_q;
  logic                   event_hit;
  pulse_state_e           state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   miss_q, miss_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

  if (FILTER_LEN == 0) begin : g_nofilt
    assign level = sync_n;
  end else begin : g_filt
    localparam logic [8:0] LIMIT = 9'(FILTER_LEN);
    logic [7:0] fcnt_q;
    logic       level_q;

    // Level flips only after FILTER_LEN consecutive disagreeing cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        fcnt_q  <= '0;
        level_q <= 1'b0;
      end else if (sync_n == level_q) begin
        fcnt_q  <= '0;
      end else if ({1'b0, fcnt_q} + 9'd1 == LIMIT) begin
        fcnt_q  <= '0;
        level_q <= ~level_q;
      end else begin
        fcnt_q  <= fcnt_q + 8'd1;
      end
    end

    assign level = level_q;
  end

  always_comb begin
    if (EDGE_MODE == EDGE_RISE)      event_hit = level & ~prev_q;
    else if (EDGE_MODE == EDGE_FALL) event_hit = ~level & prev_q;
    else                             event_hit = level ^ prev_q;
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (event_hit) begin
          state_d = ST_PULSE;
          cnt_d   = RELOAD;
        end
      end
      ST_PULSE: begin
        if (event_hit && (RETRIGGER != 0)) begin
          cnt_d = RELOAD;
        end else begin
          // A dropped event still lets the running pulse expire on schedule.
          miss_d = event_hit;
          if (cnt_q == 8'd0) state_d = ST_IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
    endcase
    pulse_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      prev_q  <= level;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      miss_q  <= miss_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign pulse_d_o = pulse_d;
  assign level_o   = level;
  assign miss_o    = miss_q;

endmodule

// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: CHANNELS independent channels plus a
// registered OR of all pulses that lines up cycle-for-cycle with o_Pulse.
module multi_edge_pulse_gen
  import edge_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int PULSE_LEN   = 1,
  parameter int RETRIGGER   = 0
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [CHANNELS-1:0] i_In,
  output logic [CHANNELS-1:0] o_Pulse,
  output logic [CHANNELS-1:0] o_Level,
  output logic [CHANNELS-1:0] o_Miss,
  output logic                o_Any
);

  if (!params_legal(CHANNELS, SYNC_STAGES, FILTER_LEN, EDGE_MODE, PULSE_LEN, RETRIGGER)) begin : g_bad_params
    $error("multi_edge_pulse_gen: illegal parameter combination");
  end

  logic [CHANNELS-1:0] pulse_d;
  logic                any_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_pulse_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .EDGE_MODE  (EDGE_MODE),
      .PULSE_LEN  (PULSE_LEN),
      .RETRIGGER  (RETRIGGER)
    ) u_ch (
      .clk_i    (i_Clk),
      .rst_i    (i_Rst),
      .in_i     (i_In[g]),
      .pulse_o  (o_Pulse[g]),
      .pulse_d_o(pulse_d[g]),
      .level_o  (o_Level[g]),
      .miss_o   (o_Miss[g])
    );
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) any_q <= 1'b0;
    else       any_q <= |pulse_d;
  end

  assign o_Any = any_q;

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Six differently-parameterised instances share one input bus; an interval-based
// model of the filter and pulse rules is compared every cycle, plus literal pins.
module tb_multi_edge_pulse_gen;

  localparam int NI   = 6;
  localparam int MAXN = 2048;
  localparam int P_S [NI] = '{2, 2, 2, 2, 3, 4};
  localparam int P_F [NI] = '{4, 0, 0, 0, 2, 3};
  localparam int P_E [NI] = '{0, 2, 2, 2, 0, 1};
  localparam int P_P [NI] = '{1, 3, 8, 8, 5, 2};
  localparam int P_R [NI] = '{0, 0, 0, 1, 1, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_in;
  logic [3:0] pulse_o [NI];
  logic [3:0] level_o [NI];
  logic [3:0] miss_o  [NI];
  logic       any_o   [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(P_S[0]), .FILTER_LEN(P_F[0]), .EDGE_MODE(P_E[0]),
    .PULSE_LEN(P_P[0]), .RETRIGGER(P_R[0])) u_a (.i_Clk(clk), .i_Rst(rst), .i_In(i_in),
    .o_Pulse(pulse_o[0]), .o_Level(level_o[0]), .o_Miss(miss_o[0]), .o_Any(any_o[0]));
  multi_edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(P_S[1]), .FILTER_LEN(P_F[1]), .EDGE_MODE(P_E[1]),
    .PULSE_LEN(P_P[1]), .RETRIGGER(P_R[1])) u_b (.i_Clk(clk), .i_Rst(rst), .i_In(i_in),
    .o_Pulse(pulse_o[1]), .o_Level(level_o[1]), .o_Miss(miss_o[1]), .o_Any(any_o[1]));
  multi_edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(P_S[2]), .FILTER_LEN(P_F[2]), .EDGE_MODE(P_E[2]),
    .PULSE_LEN(P_P[2]), .RETRIGGER(P_R[2])) u_c (.i_Clk(clk), .i_Rst(rst), .i_In(i_in),
    .o_Pulse(pulse_o[2]), .o_Level(level_o[2]), .o_Miss(miss_o[2]), .o_Any(any_o[2]));
  multi_edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(P_S[3]), .FILTER_LEN(P_F[3]), .EDGE_MODE(P_E[3]),
    .PULSE_LEN(P_P[3]), .RETRIGGER(P_R[3])) u_d (.i_Clk(clk), .i_Rst(rst), .i_In(i_in),
    .o_Pulse(pulse_o[3]), .o_Level(level_o[3]), .o_Miss(miss_o[3]), .o_Any(any_o[3]));
  multi_edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(P_S[4]), .FILTER_LEN(P_F[4]), .EDGE_MODE(P_E[4]),
    .PULSE_LEN(P_P[4]), .RETRIGGER(P_R[4])) u_e (.i_Clk(clk), .i_Rst(rst), .i_In(i_in),
    .o_Pulse(pulse_o[4]), .o_Level(level_o[4]), .o_Miss(miss_o[4]), .o_Any(any_o[4]));
  multi_edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(P_S[5]), .FILTER_LEN(P_F[5]), .EDGE_MODE(P_E[5]),
    .PULSE_LEN(P_P[5]), .RETRIGGER(P_R[5])) u_f (.i_Clk(clk), .i_Rst(rst), .i_In(i_in),
    .o_Pulse(pulse_o[5]), .o_Level(level_o[5]), .o_Miss(miss_o[5]), .o_Any(any_o[5]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   n = 0;
  logic in_hist [4][MAXN];
  logic lv_hist [NI][4][MAXN];
  int   last_ev [NI][4];

  // Synchroniser output after edge m: the input sampled S-1 edges earlier.
  function automatic logic sn(int c, int m, int s);
    int idx;
    idx = m - s + 1;
    if (idx >= 1) return in_hist[c][idx];
    return 1'b0;
  endfunction

  task automatic model_cycle();
    for (int i = 0; i < NI; i++) begin
      logic [3:0] ep, em, el;
      ep = '0; em = '0; el = '0;
      for (int c = 0; c < 4; c++) begin
        logic lv, a, b, ev, all_diff;
        if (P_F[i] == 0) begin
          lv = sn(c, n, P_S[i]);
        end else begin
          lv = lv_hist[i][c][n-1];
          if (n >= P_F[i]) begin
            all_diff = 1'b1;
            for (int m = n - P_F[i]; m < n; m++)
              if (sn(c, m, P_S[i]) == lv) all_diff = 1'b0;
            if (all_diff) lv = ~lv;
          end
        end
        lv_hist[i][c][n] = lv;
        a = lv_hist[i][c][n-1];
        b = (n >= 2) ? lv_hist[i][c][n-2] : 1'b0;
        if (P_E[i] == 0)      ev = a & ~b;
        else if (P_E[i] == 1) ev = ~a & b;
        else                  ev = a ^ b;
        if (P_R[i] != 0) begin
          if (ev) last_ev[i][c] = n;
        end else if (ev) begin
          if (n <= last_ev[i][c] + P_P[i]) em[c] = 1'b1;
          else last_ev[i][c] = n;
        end
        ep[c] = (n - last_ev[i][c] < P_P[i]);
        el[c] = lv;
      end
      check($sformatf("u%0d.o_Level n=%0d", i, n), 32'(level_o[i]), 32'(el));
      check($sformatf("u%0d.o_Pulse n=%0d", i, n), 32'(pulse_o[i]), 32'(ep));
      check($sformatf("u%0d.o_Miss n=%0d", i, n), 32'(miss_o[i]), 32'(em));
      check($sformatf("u%0d.o_Any n=%0d", i, n), 32'(any_o[i]), 32'(|ep));
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < 4; c++) begin
          last_ev[i][c]    = -1000;
          lv_hist[i][c][0] = 1'b0;
        end
      #1;
      for (int i = 0; i < NI; i++)
        check($sformatf("u%0d.reset_outputs", i),
              {19'd0, pulse_o[i], level_o[i], miss_o[i], any_o[i]}, 32'd0);
    end else if (n < MAXN - 1) begin
      n++;
      for (int c = 0; c < 4; c++) in_hist[c][n] = i_in[c];
      #1;
      model_cycle();
    end else begin
      check("model_history_overflow", 32'(n), 32'(MAXN));
    end
  end

  // ---------------- directed helpers ----------------
  int cnt_hi [NI], cnt_rise [NI], cnt_miss [NI], cnt_lvl [NI], first_rise [NI], last_rise [NI];

  task automatic at_edge(input int e);
    for (int k = 0; k < 100 && n < e; k++) begin
      @(posedge clk); #2;
    end
    check($sformatf("reach_edge_%0d", e), 32'(n), 32'(e));
  endtask

  // Drives channel ch high for hi_len cycles within a total-cycle window and tallies outputs.
  task automatic run_pattern(input int ch, input int hi_len, input int total);
    logic prev_p [NI];
    for (int i = 0; i < NI; i++) begin
      cnt_hi[i] = 0; cnt_rise[i] = 0; cnt_miss[i] = 0; cnt_lvl[i] = 0;
      first_rise[i] = -1; last_rise[i] = -1;
      prev_p[i] = pulse_o[i][ch];
    end
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      i_in[ch] = (k < hi_len);
      @(posedge clk); #2;
      for (int i = 0; i < NI; i++) begin
        if (pulse_o[i][ch]) cnt_hi[i]++;
        if (pulse_o[i][ch] && !prev_p[i]) begin
          cnt_rise[i]++;
          if (first_rise[i] < 0) first_rise[i] = k;
          last_rise[i] = k;
        end
        if (miss_o[i][ch])  cnt_miss[i]++;
        if (level_o[i][ch]) cnt_lvl[i]++;
        prev_p[i] = pulse_o[i][ch];
      end
    end
  endtask

  initial begin
    int   hold [4];
    logic seen;
    rst  = 1'b1;
    i_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Defaults: input sampled at edge 10 -> level after edge 15, single pulse at edge 16.
    repeat (9) @(negedge clk);
    i_in[0] = 1'b1;
    at_edge(14); check("a_level0_e14", 32'(level_o[0][0]), 0); check("a_pulse0_e14", 32'(pulse_o[0][0]), 0);
    at_edge(15); check("a_level0_e15", 32'(level_o[0][0]), 1); check("a_pulse0_e15", 32'(pulse_o[0][0]), 0);
    at_edge(16); check("a_pulse0_e16", 32'(pulse_o[0][0]), 1); check("a_any_e16", 32'(any_o[0]), 1);
    at_edge(17); check("a_pulse0_e17", 32'(pulse_o[0][0]), 0); check("a_any_e17", 32'(any_o[0]), 0);
    run_pattern(0, 0, 20);

    // Filter: 3-cycle glitch rejected, 4-cycle high accepted once.
    run_pattern(1, 3, 20);
    check("a_glitch3_pulses", 32'(cnt_hi[0]), 0);
    check("a_glitch3_level",  32'(cnt_lvl[0]), 0);
    run_pattern(1, 4, 25);
    check("a_high4_pulses", 32'(cnt_hi[0]), 1);
    check("a_high4_rises",  32'(cnt_rise[0]), 1);
    check("a_high4_level",  32'(cnt_lvl[0]), 4);

    // Both edges, 3-cycle pulses on a 10-cycle high.
    run_pattern(2, 10, 30);
    check("b_both_hi",    32'(cnt_hi[1]), 6);
    check("b_both_rises", 32'(cnt_rise[1]), 2);
    check("b_both_gap",   32'(last_rise[1] - first_rise[1]), 10);

    // Events 3 cycles apart into an 8-cycle stretcher, without and with retrigger.
    run_pattern(0, 3, 30);
    check("c_noretrig_hi",    32'(cnt_hi[2]), 8);
    check("c_noretrig_miss",  32'(cnt_miss[2]), 1);
    check("c_noretrig_rises", 32'(cnt_rise[2]), 1);
    check("d_retrig_hi",      32'(cnt_hi[3]), 11);
    check("d_retrig_rises",   32'(cnt_rise[3]), 1);
    check("d_retrig_miss",    32'(cnt_miss[3]), 0);

    // Input held high through reset release counts as a rising edge.
    @(negedge clk); rst = 1'b1; i_in = 4'b1000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    at_edge(6); check("a_held_pulse3_e6", 32'(pulse_o[0][3]), 0);
    at_edge(7); check("a_held_pulse3_e7", 32'(pulse_o[0][3]), 1); check("a_held_any_e7", 32'(any_o[0]), 1);
    at_edge(8); check("a_held_pulse3_e8", 32'(pulse_o[0][3]), 0);
    @(negedge clk); i_in[3] = 1'b0;
    run_pattern(3, 0, 20);

    // Asynchronous reset in the 2nd cycle of a 5-cycle pulse.
    @(negedge clk); i_in[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #2;
      seen = pulse_o[4][1];
    end
    check("e_pulse_started", 32'(seen), 1);
    @(posedge clk); #2;
    check("e_pulse_2nd_cycle", 32'(pulse_o[4][1]), 1);
    #1 rst = 1'b1;
    #1;
    check("e_async_rst_pulse", 32'(pulse_o[4]), 0);
    check("e_async_rst_any",   32'(any_o[4]), 0);
    i_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_pattern(1, 0, 30);
    check("e_no_pulse_after_rst", 32'(cnt_hi[4]), 0);

    // Randomised run-length stimulus, checked by the model every cycle.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          i_in[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 9);
        end else begin
          hold[c]--;
        end
      end
    end
    i_in = '0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
